tmds_encoder: RTL and testbench

Three-channel DVI/TMDS 8b/10b encoder feeding the HDMI serializer. Runs on the 10x serial clock and advances one pixel per `pi_pix_en` strobe. Converts 8-bit RGB plus DE/HSYNC/VSYNC into DC-balanced 10-bit symbols. Each symbol is held stable for the whole 10-cycle serializer window.

---
 rtl/tmds_encoder.sv | 231 +++++++++++++++++++++++
 tb/tb_tmds_encoder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
// tmds_encoder
// ------------
// Three-channel DVI/TMDS 8b/10b encoder running on the 10x serial clock.
// One pixel advances through the pipeline per pi_pix_en strobe; between
// strobes every register holds, so each 10-bit symbol stays stable for the
// whole serializer window.
//
// Pipeline:
//   stage 1 : input register (DE, syncs, RGB)
//   stage 2 : transition-minimised q_m per channel (registered)
//   [extra  : q_m/DE/sync register, only with TMDS_ENC_PIPE_EN]
//   stage 3 : DC balance / control tokens, output register + disparity cnt
// Latency: pixel on strobe k -> outputs in the cycle after strobe k+2
// (k+3 when TMDS_ENC_PIPE_EN is defined). Symbol values are identical in
// both builds.
//
// Configuration macro: TMDS_ENC_PIPE_EN (adds the stage 2 -> 3 register).
//
// Ports:
//   pi_clk                      serial-rate clock (10x pixel rate)
//   pi_rst                      synchronous active-high reset, wins over pi_pix_en
//   pi_pix_en                   pixel strobe
//   pi_de, pi_hsync, pi_vsync   data enable and syncs (blue C0/C1)
//   pi_red, pi_green, pi_blue   8-bit pixel components
//   po_red, po_green, po_blue   10-bit TMDS symbols, bit 0 sent first
//   po_valid                    new-symbol pulse
//
// Handshake: there is no ready. po_valid is a one-cycle presentation strobe
// asserted in the cycle after every accepted pi_pix_en; the symbols it
// marks stay valid until the next po_valid. The serializer must sample
// them away from that update cycle.

module tmds_encoder (
  input  logic       pi_clk,
  input  logic       pi_rst,
  input  logic       pi_pix_en,
  input  logic       pi_de,
  input  logic       pi_hsync,
  input  logic       pi_vsync,
  input  logic [7:0] pi_red,
  input  logic [7:0] pi_green,
  input  logic [7:0] pi_blue,
  output logic [9:0] po_red,
  output logic [9:0] po_green,
  output logic [9:0] po_blue,
  output logic       po_valid
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;

  // Channel index: 0 = blue, 1 = green, 2 = red.

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------
  function automatic logic [3:0] ones8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

  function automatic logic [8:0] trans_min(input logic [7:0] d);
    logic [3:0] n;
    logic       use_xnor;
    logic [8:0] q;
    n        = ones8(d);
    use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
    q        = 9'd0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  // Returns {next_cnt[4:0], symbol[9:0]}. Arithmetic is done in 6 bits so
  // the intermediate 2*n1 (up to 16) cannot wrap.
  function automatic logic [14:0] dc_bal(input logic [8:0] qm,
                                         input logic [4:0] cnt);
    logic signed [5:0] c;
    logic signed [5:0] d;   // n1 - n0 of qm[7:0]
    logic signed [5:0] nc;
    logic [9:0]        sym;
    c = $signed({cnt[4], cnt});
    d = $signed({1'b0, ones8(qm[7:0]), 1'b0}) - 6'sd8;
    if ((c == 6'sd0) || (d == 6'sd0)) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      nc  = qm[8] ? (c + d) : (c - d);
    end else if (((c > 6'sd0) && (d > 6'sd0)) ||
                 ((c < 6'sd0) && (d < 6'sd0))) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      nc  = c - d + (qm[8] ? 6'sd2 : 6'sd0);
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      nc  = c + d - (qm[8] ? 6'sd0 : 6'sd2);
    end
    return {nc[4:0], sym};
  endfunction

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = 10'b1101010100;
      2'b01:   t = 10'b0010101011;
      2'b10:   t = 10'b0101010100;
      default: t = 10'b1010101011;
    endcase
    return t;
  endfunction

  // ---------------------------------------------------------------------
  // Stage 1 and stage 2 registers
  // ---------------------------------------------------------------------
  logic            s1_de_q, s1_hs_q, s1_vs_q;
  logic [2:0][7:0] s1_data_q;
  logic            s2_de_q, s2_hs_q, s2_vs_q;
  logic [2:0][8:0] s2_qm_q, s2_qm_d;

  always_comb begin
    s2_qm_d = '0;
    for (int ch = 0; ch < 3; ch++) begin
      s2_qm_d[ch] = trans_min(s1_data_q[ch]);
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3 inputs (optionally through the extra register)
  // ---------------------------------------------------------------------
  logic            s3_de, s3_hs, s3_vs;
  logic [2:0][8:0] s3_qm;

`ifdef TMDS_ENC_PIPE_EN
  logic            sp_de_q, sp_hs_q, sp_vs_q;
  logic [2:0][8:0] sp_qm_q;

  always_ff @(posedge pi_clk) begin
    if (pi_rst) begin
      sp_de_q <= 1'b0;
      sp_hs_q <= 1'b0;
      sp_vs_q <= 1'b0;
      sp_qm_q <= '0;
    end else if (pi_pix_en) begin
      sp_de_q <= s2_de_q;
      sp_hs_q <= s2_hs_q;
      sp_vs_q <= s2_vs_q;
      sp_qm_q <= s2_qm_q;
    end
  end

  assign s3_de = sp_de_q;
  assign s3_hs = sp_hs_q;
  assign s3_vs = sp_vs_q;
  assign s3_qm = sp_qm_q;
`else
  assign s3_de = s2_de_q;
  assign s3_hs = s2_hs_q;
  assign s3_vs = s2_vs_q;
  assign s3_qm = s2_qm_q;
`endif

  // ---------------------------------------------------------------------
  // Stage 3: DC balance and control tokens
  // ---------------------------------------------------------------------
  logic [2:0][9:0]  sym_q, sym_d;
  logic [2:0][4:0]  cnt_q, cnt_d;
  logic [2:0][14:0] bal;
  logic             valid_q;

  always_comb begin
    bal = '0;
    for (int ch = 0; ch < 3; ch++) begin
      bal[ch] = dc_bal(s3_qm[ch], cnt_q[ch]);
    end
  end

  // Blanking clears the disparity so the first active pixel after it
  // always encodes from cnt = 0.
  always_comb begin
    sym_d = sym_q;
    cnt_d = cnt_q;
    for (int ch = 0; ch < 3; ch++) begin
      if (s3_de) begin
        sym_d[ch] = bal[ch][9:0];
        cnt_d[ch] = bal[ch][14:10];
      end else begin
        sym_d[ch] = (ch == 0) ? ctrl_token({s3_vs, s3_hs}) : CTRL_00;
        cnt_d[ch] = 5'd0;
      end
    end
  end

  always_ff @(posedge pi_clk) begin
    if (pi_rst) begin
      s1_de_q   <= 1'b0;
      s1_hs_q   <= 1'b0;
      s1_vs_q   <= 1'b0;
      s1_data_q <= '0;
      s2_de_q   <= 1'b0;
      s2_hs_q   <= 1'b0;
      s2_vs_q   <= 1'b0;
      s2_qm_q   <= '0;
      sym_q     <= {3{CTRL_00}};
      cnt_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= pi_pix_en;
      if (pi_pix_en) begin
        s1_de_q   <= pi_de;
        s1_hs_q   <= pi_hsync;
        s1_vs_q   <= pi_vsync;
        s1_data_q <= {pi_red, pi_green, pi_blue};
        s2_de_q   <= s1_de_q;
        s2_hs_q   <= s1_hs_q;
        s2_vs_q   <= s1_vs_q;
        s2_qm_q   <= s2_qm_d;
        sym_q     <= sym_d;
        cnt_q     <= cnt_d;
      end
    end
  end

  assign po_blue  = sym_q[0];
  assign po_green = sym_q[1];
  assign po_red   = sym_q[2];
  assign po_valid = valid_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder
// ---------------
// Bench for tmds_encoder. A behavioural model (pixel delay queue plus the
// TMDS encoding rules in integer arithmetic) predicts the symbols and
// po_valid on every cycle; a compare process checks the DUT at each falling
// edge. Directed sequences pin the model to hand-computed literal symbols.

module tb_tmds_encoder;

`ifdef TMDS_ENC_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  localparam logic [9:0] TOK_LIT [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  localparam logic [9:0] DC_LIT  [4] = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};
  localparam int         CNT_LIT [4] = '{-8, 2, -6, 4};

  // ---------------- clock / reset ----------------
  logic       pi_clk    = 1'b0;
  logic       pi_rst    = 1'b1;
  logic       pi_pix_en = 1'b0;
  logic       pi_de     = 1'b0;
  logic       pi_hsync  = 1'b0;
  logic       pi_vsync  = 1'b0;
  logic [7:0] pi_red    = 8'd0;
  logic [7:0] pi_green  = 8'd0;
  logic [7:0] pi_blue   = 8'd0;
  logic [9:0] po_red, po_green, po_blue;
  logic       po_valid;

  always #5 pi_clk = ~pi_clk;

  tmds_encoder dut (
    .pi_clk   (pi_clk),
    .pi_rst   (pi_rst),
    .pi_pix_en(pi_pix_en),
    .pi_de    (pi_de),
    .pi_hsync (pi_hsync),
    .pi_vsync (pi_vsync),
    .pi_red   (pi_red),
    .pi_green (pi_green),
    .pi_blue  (pi_blue),
    .po_red   (po_red),
    .po_green (po_green),
    .po_blue  (po_blue),
    .po_valid (po_valid)
  );

  // ---------------- scoreboard state ----------------
  int          tests = 0;
  int          fails = 0;
  bit          chk_en = 1'b0;
  logic [26:0] exp_q[$];      // {de, vsync, hsync, red, green, blue} in flight
  logic [9:0]  cap_q[$];      // DUT blue symbol at each po_valid
  int          cnt_cap_q[$];  // model blue cnt after each strobe
  logic [9:0]  exp_sym [3];   // 0 blue, 1 green, 2 red
  logic        exp_valid;
  int          cnt_m [3];
  int          max_abs = 0;
  int          strobes = 0;
  int          pulses  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_cap(input string name, input int idx, input logic [9:0] req);
    if (idx >= cap_q.size()) begin
      tests++;
      fails++;
      $display("FAIL %s: symbol %0d never presented, expected 0x%0h", name, idx, req);
    end else begin
      check(name, 32'(cap_q[idx]), 32'(req));
    end
  endtask

  task automatic check_cnt(input string name, input int idx, input int req);
    if (idx >= cnt_cap_q.size()) begin
      tests++;
      fails++;
      $display("FAIL %s: cnt %0d missing, expected %0d", name, idx, req);
    end else begin
      check_int(name, cnt_cap_q[idx], req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [9:0] tok(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  task automatic enc_ch(input logic [7:0] d, inout int cnt, output logic [9:0] sym);
    int         n1d, n1, n0;
    logic       use_xnor;
    logic [8:0] qm;
    n1d      = $countones(d);
    use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    end
    qm[8] = !use_xnor;
    n1    = $countones(qm[7:0]);
    n0    = 8 - n1;
    if (cnt == 0 || n1 == n0) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt = cnt + (qm[8] ? (n1 - n0) : (n0 - n1));
    end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      cnt = cnt + (qm[8] ? 2 : 0) + (n0 - n1);
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      cnt = cnt - (qm[8] ? 0 : 2) + (n1 - n0);
    end
  endtask

  always @(posedge pi_clk) begin
    logic [26:0] px;
    if (pi_rst) begin
      exp_q.delete();
      for (int i = 0; i < LAT; i++) exp_q.push_back(27'd0);
      cnt_m     = '{0, 0, 0};
      exp_sym   = '{10'h354, 10'h354, 10'h354};
      exp_valid = 1'b0;
    end else begin
      exp_valid = pi_pix_en;
      if (pi_pix_en) begin
        strobes++;
        exp_q.push_back({pi_de, pi_vsync, pi_hsync, pi_red, pi_green, pi_blue});
        px = exp_q.pop_front();
        if (px[26]) begin
          enc_ch(px[7:0],   cnt_m[0], exp_sym[0]);
          enc_ch(px[15:8],  cnt_m[1], exp_sym[1]);
          enc_ch(px[23:16], cnt_m[2], exp_sym[2]);
        end else begin
          exp_sym[0] = tok({px[25], px[24]});
          exp_sym[1] = tok(2'b00);
          exp_sym[2] = tok(2'b00);
          cnt_m      = '{0, 0, 0};
        end
        for (int ch = 0; ch < 3; ch++) begin
          if (cnt_m[ch] > max_abs)  max_abs = cnt_m[ch];
          if (-cnt_m[ch] > max_abs) max_abs = -cnt_m[ch];
        end
        cnt_cap_q.push_back(cnt_m[0]);
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge pi_clk) begin
    if (chk_en) begin
      check("po_blue",  32'(po_blue),  32'(exp_sym[0]));
      check("po_green", 32'(po_green), 32'(exp_sym[1]));
      check("po_red",   32'(po_red),   32'(exp_sym[2]));
      check("po_valid", 32'(po_valid), 32'(exp_valid));
      if (po_valid === 1'b1) begin
        pulses++;
        cap_q.push_back(po_blue);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_pix(input logic de, input logic hs, input logic vs,
                           input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b, input int gap);
    pi_de     = de;
    pi_hsync  = hs;
    pi_vsync  = vs;
    pi_red    = r;
    pi_green  = g;
    pi_blue   = b;
    pi_pix_en = 1'b1;
    @(negedge pi_clk);
    pi_pix_en = 1'b0;
    repeat (gap - 1) @(negedge pi_clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge pi_clk);
    pi_rst    = 1'b1;
    pi_pix_en = 1'b0;
    repeat (n) @(negedge pi_clk);
    pi_rst = 1'b0;
    chk_en = 1'b1;
    cap_q.delete();
    cnt_cap_q.delete();
  endtask

  task automatic flush();
    repeat (LAT) drive_pix(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 10);
    repeat (2) @(negedge pi_clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic       de;
    int         run;
    logic [1:0] c;

    // Reset values, and persistence with no strobes.
    do_reset(3);
    check("rst_blue",  32'(po_blue),  32'h354);
    check("rst_green", 32'(po_green), 32'h354);
    check("rst_red",   32'(po_red),   32'h354);
    check("rst_valid", 32'(po_valid), 32'h0);
    repeat (15) @(negedge pi_clk);
    check("idle_blue",  32'(po_blue), 32'h354);
    check("idle_red",   32'(po_red),  32'h354);
    check("idle_valid", 32'(po_valid), 32'h0);

    // Control tokens on blue for {vsync,hsync} = 00,01,10,11.
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      c = 2'(i);
      drive_pix(1'b0, c[0], c[1], 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 10);
    end
    flush();
    for (int i = 0; i < 4; i++) begin
      check_cap($sformatf("ctrl_tok%0d", i), LAT + i, TOK_LIT[i]);
    end

    // DC balance on blue = 0x00 from cnt = 0, plus DE 0->1 latency.
    do_reset(2);
    for (int i = 0; i < 4; i++) drive_pix(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 10);
    flush();
    check_cap("lat_before_de", LAT - 1, 10'h354);
    for (int i = 0; i < 4; i++) begin
      check_cap($sformatf("dc_sym%0d", i), LAT + i, DC_LIT[i]);
      check_cnt($sformatf("dc_cnt%0d", i), LAT + i, CNT_LIT[i]);
    end

    // Random video with random blanking; strobe every 10 cycles first,
    // then continuously.
    de  = 1'b0;
    run = 0;
    for (int i = 0; i < 10000; i++) begin
      if (run == 0) begin
        de  = ~de;
        run = int'($urandom_range(1, 40));
      end
      run--;
      drive_pix(de, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), (i < 1500) ? 10 : 1);
    end
    repeat (3) @(negedge pi_clk);

    // Mid-frame reset during active video (with a simultaneous strobe).
    for (int i = 0; i < 20; i++) begin
      drive_pix(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 10);
    end
    repeat (3) @(negedge pi_clk);
    pi_de     = 1'b1;
    pi_pix_en = 1'b1;
    pi_rst    = 1'b1;
    @(negedge pi_clk);
    check("midrst_blue",  32'(po_blue),  32'h354);
    check("midrst_green", 32'(po_green), 32'h354);
    check("midrst_valid", 32'(po_valid), 32'h0);
    pi_rst    = 1'b0;
    pi_pix_en = 1'b0;
    cap_q.delete();
    cnt_cap_q.delete();
    for (int i = 0; i < 2; i++) drive_pix(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 10);
    flush();
    check_cap("midrst_first",  LAT,     10'h100);
    check_cap("midrst_second", LAT + 1, 10'h3FF);

    // Aggregate checks.
    tests++;
    if (max_abs > 10) begin
      fails++;
      $display("FAIL cnt_range: max |cnt| %0d, required <= 10", max_abs);
    end
    check_int("valid_pulses", pulses, strobes);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
